// File: rtl/dpll_pkg.sv
// Shared types and constants for the DPLL reference clock generator.
// The LFSR constants are used only when DPLL_FIN_GEN_DITHER_EN is defined.
package dpll_pkg;

   typedef enum logic {FTW_IDLE, FTW_PENDING} ftw_state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic lfsr_feedback(input logic [15:0] s);
      return ^(s & LFSR_TAPS);
   endfunction

endpackage

// File: rtl/dpll_lfsr16.sv
// 16-bit Fibonacci LFSR used as a cycle-to-cycle jitter source for the NCO.
// Advances only on enabled cycles so it freezes together with the accumulator.
module dpll_lfsr16
   import dpll_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic [15:0] state
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= LFSR_SEED;
      end else if (enable) begin
         state <= {state[14:0], lfsr_feedback(state)};
      end
   end

endmodule

// File: rtl/dpll_fin_gen.sv
// Phase-accumulator square-wave source driving the DPLL clk_fin input, with
// FTW reload and phase-step handshakes. Define DPLL_FIN_GEN_DITHER_EN for LFSR dither.
module dpll_fin_gen
   import dpll_pkg::*;
#(
   parameter int                   ACC_WIDTH   = 16,
   parameter logic [ACC_WIDTH-1:0] FTW_DEFAULT = 16'h0200
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [ACC_WIDTH-1:0] ftw_in,
   input  logic                 ftw_valid,
   output logic                 ftw_ready,
   input  logic [ACC_WIDTH-1:0] step_in,
   input  logic                 step_valid,
   output logic                 step_ready,
   output logic                 clk_fin_out,
   output logic                 clk8x_out,
   output logic                 wrap
);

   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH-1:0] ftw_active;
   logic [ACC_WIDTH-1:0] ftw_pend;
   logic [ACC_WIDTH-1:0] step_pend;
   logic [ACC_WIDTH-1:0] step_add;
   logic [ACC_WIDTH:0]   sum;
   logic                 carry;
   logic                 step_pending;
   ftw_state_t           ftw_state;

`ifdef DPLL_FIN_GEN_DITHER_EN
   logic [15:0] lfsr_state;

   dpll_lfsr16 u_lfsr (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .state  (lfsr_state)
   );

   always_comb begin
      step_add = step_pending ? step_pend : '0;
      sum = {1'b0, acc} + {1'b0, ftw_active} + {1'b0, step_add}
          + (ACC_WIDTH+1)'(lfsr_state[1:0]);
      carry = sum[ACC_WIDTH];
   end
`else
   always_comb begin
      step_add = step_pending ? step_pend : '0;
      sum = {1'b0, acc} + {1'b0, ftw_active} + {1'b0, step_add};
      carry = sum[ACC_WIDTH];
   end
`endif

   // Outputs decode the accumulator register directly, so they cannot glitch
   assign clk_fin_out = acc[ACC_WIDTH-1];
   assign clk8x_out   = acc[ACC_WIDTH-4];
   assign ftw_ready   = (ftw_state == FTW_IDLE);
   assign step_ready  = ~step_pending;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc  <= '0;
         wrap <= 1'b0;
      end else if (enable) begin
         acc  <= sum[ACC_WIDTH-1:0];
         wrap <= carry;
      end else begin
         wrap <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_pending <= 1'b0;
      end else if (step_pending) begin
         if (enable) step_pending <= 1'b0;
      end else if (step_valid) begin
         step_pending <= 1'b1;
      end
   end

   // The new FTW takes over only at a carry so the output phase stays continuous
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ftw_state  <= FTW_IDLE;
         ftw_active <= FTW_DEFAULT;
      end else if (ftw_state == FTW_IDLE) begin
         if (ftw_valid) ftw_state <= FTW_PENDING;
      end else if (enable && (carry || ftw_active == '0)) begin
         ftw_active <= ftw_pend;
         ftw_state  <= FTW_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (ftw_valid && ftw_ready)   ftw_pend  <= ftw_in;
      if (step_valid && step_ready) step_pend <= step_in;
   end

endmodule

// File: tb/tb_dpll_fin_gen.sv
// Directed vector bench for dpll_fin_gen with ACC_WIDTH=8, FTW_DEFAULT=8'h20.
module tb_dpll_fin_gen;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [7:0] ftw_in;
   logic       ftw_valid;
   logic       ftw_ready;
   logic [7:0] step_in;
   logic       step_valid;
   logic       step_ready;
   logic       clk_fin_out;
   logic       clk8x_out;
   logic       wrap;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       en;
      logic       fv;
      logic [7:0] fi;
      logic       sv;
      logic [7:0] si;
      logic [7:0] acc;
      logic       wrap;
      logic       fr;
      logic       sr;
   } vec_t;

   vec_t vecs[$];

   dpll_fin_gen #(
      .ACC_WIDTH   (8),
      .FTW_DEFAULT (8'h20)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .ftw_in      (ftw_in),
      .ftw_valid   (ftw_valid),
      .ftw_ready   (ftw_ready),
      .step_in     (step_in),
      .step_valid  (step_valid),
      .step_ready  (step_ready),
      .clk_fin_out (clk_fin_out),
      .clk8x_out   (clk8x_out),
      .wrap        (wrap)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int row, input logic [7:0] got,
                        input logic [7:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s row=%0d got=%h want=%h", name, row, got, want);
      end
   endtask

   task automatic push(input logic en, input logic fv, input logic [7:0] fi,
                       input logic sv, input logic [7:0] si, input logic [7:0] a,
                       input logic w, input logic fr, input logic sr);
      vec_t v;
      v.en = en; v.fv = fv; v.fi = fi; v.sv = sv; v.si = si;
      v.acc = a; v.wrap = w; v.fr = fr; v.sr = sr;
      vecs.push_back(v);
   endtask

   task automatic check_all(input int row, input logic [7:0] a, input logic w,
                            input logic fr, input logic sr);
      logic [7:0] want_fin;
      logic [7:0] want_8x;
      want_fin = {7'd0, a[7]};
      want_8x  = {7'd0, a[4]};
      check("acc", row, dut.acc, a);
      check("wrap", row, {7'd0, wrap}, {7'd0, w});
      check("clk_fin_out", row, {7'd0, clk_fin_out}, want_fin);
      check("clk8x_out", row, {7'd0, clk8x_out}, want_8x);
      check("ftw_ready", row, {7'd0, ftw_ready}, {7'd0, fr});
      check("step_ready", row, {7'd0, step_ready}, {7'd0, sr});
   endtask

   initial begin
      // Default FTW 0x20: 8-cycle period, then a 0x80 step landing at acc=00
      for (int k = 1; k <= 7; k++) push(1, 0, 0, 0, 0, 8'(k * 32), 0, 1, 1);
      push(1, 0, 0, 1, 8'h80, 8'h00, 1, 1, 0);
      push(1, 0, 0, 0, 0, 8'hA0, 0, 1, 1);
      push(1, 0, 0, 0, 0, 8'hC0, 0, 1, 1);
      push(1, 0, 0, 0, 0, 8'hE0, 0, 1, 1);
      push(1, 0, 0, 0, 0, 8'h00, 1, 1, 1);
      push(1, 0, 0, 0, 0, 8'h20, 0, 1, 1);
      // FTW 0x10 loaded mid-period, takes effect after the next carry
      push(1, 1, 8'h10, 0, 0, 8'h40, 0, 0, 1);
      for (int k = 3; k <= 7; k++) push(1, 0, 0, 0, 0, 8'(k * 32), 0, 0, 1);
      push(1, 0, 0, 0, 0, 8'h00, 1, 1, 1);
      for (int k = 1; k <= 15; k++) push(1, 0, 0, 0, 0, 8'(k * 16), 0, 1, 1);
      push(1, 0, 0, 0, 0, 8'h00, 1, 1, 1);
      // FTW 0x40 and step 0x10 together
      push(1, 1, 8'h40, 1, 8'h10, 8'h10, 0, 0, 0);
      push(1, 0, 0, 0, 0, 8'h30, 0, 0, 1);
      for (int k = 4; k <= 15; k++) push(1, 0, 0, 0, 0, 8'(k * 16), 0, 0, 1);
      push(1, 0, 0, 0, 0, 8'h00, 1, 1, 1);
      push(1, 0, 0, 0, 0, 8'h40, 0, 1, 1);
      push(1, 0, 0, 0, 0, 8'h80, 0, 1, 1);
      push(1, 0, 0, 0, 0, 8'hC0, 0, 1, 1);
      push(1, 0, 0, 0, 0, 8'h00, 1, 1, 1);
      // Disabled for 5 cycles with a step pending
      push(0, 0, 0, 1, 8'h08, 8'h00, 0, 1, 0);
      for (int k = 0; k < 4; k++) push(0, 0, 0, 0, 0, 8'h00, 0, 1, 0);
      push(1, 0, 0, 0, 0, 8'h48, 0, 1, 1);
      push(1, 0, 0, 0, 0, 8'h88, 0, 1, 1);
      push(1, 0, 0, 0, 0, 8'hC8, 0, 1, 1);
      push(1, 0, 0, 0, 0, 8'h08, 1, 1, 1);
      // FTW of zero, then a reload while the active FTW is zero
      push(1, 1, 8'h00, 0, 0, 8'h48, 0, 0, 1);
      push(1, 0, 0, 0, 0, 8'h88, 0, 0, 1);
      push(1, 0, 0, 0, 0, 8'hC8, 0, 0, 1);
      push(1, 0, 0, 0, 0, 8'h08, 1, 1, 1);
      push(1, 0, 0, 0, 0, 8'h08, 0, 1, 1);
      push(1, 1, 8'h30, 0, 0, 8'h08, 0, 0, 1);
      push(1, 0, 0, 0, 0, 8'h08, 0, 1, 1);
      push(1, 0, 0, 0, 0, 8'h38, 0, 1, 1);
      // Leave an FTW and a step pending for the asynchronous reset
      push(1, 1, 8'h80, 0, 0, 8'h68, 0, 0, 1);
      push(1, 0, 0, 1, 8'h05, 8'h98, 0, 0, 0);

      reset = 1'b0; enable = 1'b0; ftw_in = '0; ftw_valid = 1'b0;
      step_in = '0; step_valid = 1'b0;
      #1 reset = 1'b1;
      #1;
      check_all(-1, 8'h00, 0, 1, 1);
      check("ftw_active_reset", -1, dut.ftw_active, 8'h20);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         enable = vecs[i].en; ftw_valid = vecs[i].fv; ftw_in = vecs[i].fi;
         step_valid = vecs[i].sv; step_in = vecs[i].si;
         @(posedge clk);
         #1;
         check_all(i, vecs[i].acc, vecs[i].wrap, vecs[i].fr, vecs[i].sr);
         @(negedge clk);
      end

      // Asynchronous reset between clock edges, pending FTW and step discarded
      enable = 1'b1; ftw_valid = 1'b0; step_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check_all(900, 8'h00, 0, 1, 1);
      check("ftw_active_async", 900, dut.ftw_active, 8'h20);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      check_all(901, 8'h20, 0, 1, 1);
      @(posedge clk);
      #1;
      check_all(902, 8'h40, 0, 1, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
